imem_loader: RTL and testbench

- Write-side front end for the 4-bank, 256-bit input memory block.
- Accepts a narrow valid/ready word stream and packs it into 256-bit lines.
- Writes each completed line into the next free bank and tracks bank occupancy for the downstream consumer.
- Shares the memory's single bank-select port with the consumer's read requests; reads always win and a pending write is deferred.

---
 rtl/imem_loader_if.sv | 37 +++
 rtl/imem_loader.sv | 94 +++++++++
 tb/tb_imem_loader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module : imem_loader_if
// Brief  : Word stream, consumer read/release and memory-port bundle for the
//          input-memory loader.
// Rev    : 1.0  initial release
// ============================================================================
interface imem_loader_if #(
    parameter int WORD_W = 32
);
    logic              s_valid;
    logic [WORD_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;
    logic              rd_req;
    logic [1:0]        rd_bank;
    logic              rel_valid;
    logic [1:0]        rel_bank;
    logic              mem_wr;
    logic              mem_rd;
    logic [1:0]        mem_bank;
    logic [255:0]      mem_data;
    logic [3:0]        bank_full;

    // Loader side.
    modport slave (
        input  s_valid, s_data, s_last, rd_req, rd_bank, rel_valid, rel_bank,
        output s_ready, mem_wr, mem_rd, mem_bank, mem_data, bank_full
    );

    // Producer / consumer / environment side.
    modport master (
        output s_valid, s_data, s_last, rd_req, rd_bank, rel_valid, rel_bank,
        input  s_ready, mem_wr, mem_rd, mem_bank, mem_data, bank_full
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module : imem_loader
// Brief  : Packs a narrow word stream into 256-bit lines and writes them into
//          a 4-bank memory in order, yielding the bank port to reads.
// Rev    : 1.0  initial release
// ============================================================================
module imem_loader #(
    parameter int WORD_W = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    imem_loader_if.slave bus
);
    localparam int c_LINE_W = 256;
    localparam int c_N      = c_LINE_W / WORD_W;
    localparam int c_CNT_W  = (c_N > 1) ? $clog2(c_N) : 1;

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_WPEND = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [1:0]          r_wr_ptr;
    logic [c_LINE_W-1:0] r_line;
    logic [3:0]          r_bank_full;

    logic                w_accept;
    logic                w_last_word;
    logic                w_write;
    logic [3:0]          w_rel_mask;
    logic [3:0]          w_set_mask;

    assign bus.s_ready = reset_n && (r_state == ST_FILL) && !r_bank_full[r_wr_ptr];
    assign w_accept    = bus.s_valid && bus.s_ready;
    assign w_last_word = bus.s_last || (r_cnt == c_CNT_W'(c_N - 1));

    // A pending line only reaches the bank port in a cycle with no read request.
    assign w_write     = reset_n && (r_state == ST_WPEND) && !bus.rd_req;

    assign w_rel_mask  = bus.rel_valid ? (4'b0001 << bus.rel_bank) : 4'b0000;
    assign w_set_mask  = w_write       ? (4'b0001 << r_wr_ptr)     : 4'b0000;

    assign bus.mem_wr    = w_write;
    assign bus.mem_rd    = reset_n && bus.rd_req;
    assign bus.mem_bank  = w_write ? r_wr_ptr : bus.rd_bank;
    assign bus.mem_data  = r_line;
    assign bus.bank_full = r_bank_full;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_FILL;
            r_cnt       <= '0;
            r_wr_ptr    <= 2'd0;
            r_line      <= '0;
            r_bank_full <= 4'b0000;
        end else begin
            // Set only ever targets an empty bank, so release/set never collide.
            r_bank_full <= (r_bank_full & ~w_rel_mask) | w_set_mask;

            case (r_state)
                ST_FILL: begin
                    if (w_accept) begin
                        for (int i = 0; i < c_N; i++) begin
                            if (r_cnt == c_CNT_W'(i)) begin
                                r_line[i*WORD_W +: WORD_W] <= bus.s_data;
                            end
                        end
                        if (w_last_word) begin
                            r_state <= ST_WPEND;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_WPEND: begin
                    // Clearing here makes the zero-fill of short lines implicit.
                    if (!bus.rd_req) begin
                        r_wr_ptr <= r_wr_ptr + 2'd1;
                        r_line   <= '0;
                        r_state  <= ST_FILL;
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_imem_loader
// Brief  : Directed table-driven bench for imem_loader.
// Rev    : 1.0  initial release
// ============================================================================
module tb_imem_loader;
    localparam int c_W = 32;

    logic clock = 1'b0;
    logic reset_n;

    imem_loader_if #(.WORD_W(c_W)) bus ();

    imem_loader #(.WORD_W(c_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic         v;
        logic [31:0]  d;
        logic         l;
        logic         rq;
        logic [1:0]   rb;
        logic         e_rdy;
        logic         e_wr;
        logic         e_rd;
        logic [1:0]   e_bank;
        logic [3:0]   e_full;
        logic         chk_data;
        logic [255:0] e_data;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mkv(input logic v, input logic [31:0] d, input logic l,
                                 input logic rq, input logic [1:0] rb,
                                 input logic e_rdy, input logic e_wr, input logic e_rd,
                                 input logic [1:0] e_bank, input logic [3:0] e_full,
                                 input logic chk_data, input logic [255:0] e_data);
        vec_t x;
        x.v = v; x.d = d; x.l = l; x.rq = rq; x.rb = rb;
        x.e_rdy = e_rdy; x.e_wr = e_wr; x.e_rd = e_rd; x.e_bank = e_bank;
        x.e_full = e_full; x.chk_data = chk_data; x.e_data = e_data;
        return x;
    endfunction

    function automatic logic [255:0] mk_line(input logic [31:0] base, input int n);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i*32 +: 32] = base + 32'(i);
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs just after the edge, return mid-cycle for sampling.
    task automatic step(input logic v, input logic [31:0] d, input logic l,
                        input logic rq, input logic [1:0] rb,
                        input logic rv, input logic [1:0] rlb);
        @(posedge clock);
        #1;
        bus.s_valid = v; bus.s_data = d; bus.s_last = l;
        bus.rd_req = rq; bus.rd_bank = rb;
        bus.rel_valid = rv; bus.rel_bank = rlb;
        #4;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    endtask

    task automatic send_line(input logic [31:0] base, input int n, input logic [1:0] bank);
        for (int i = 0; i < n; i++) begin
            step(1'b1, base + 32'(i), (i == n - 1), 1'b0, 2'd0, 1'b0, 2'd0);
            chk($sformatf("line%0h accept%0d s_ready", base, i), 256'(bus.s_ready), 256'(1));
        end
        idle();
        chk($sformatf("line%0h mem_wr", base),   256'(bus.mem_wr),   256'(1));
        chk($sformatf("line%0h mem_bank", base), 256'(bus.mem_bank), 256'(bank));
        chk($sformatf("line%0h mem_data", base), bus.mem_data,       mk_line(base, n));
        chk($sformatf("line%0h s_ready", base),  256'(bus.s_ready),  256'(0));
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #1;
        bus.s_valid = 1'b1; bus.s_last = 1'b0; bus.rd_req = 1'b1;
        bus.rel_valid = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        chk("rst s_ready",   256'(bus.s_ready),   256'(0));
        chk("rst mem_wr",    256'(bus.mem_wr),    256'(0));
        chk("rst mem_rd",    256'(bus.mem_rd),    256'(0));
        chk("rst bank_full", 256'(bus.bank_full), 256'(0));
        chk("rst mem_data",  bus.mem_data,        256'(0));
        @(posedge clock);
        #1;
        bus.s_valid = 1'b0; bus.rd_req = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        vecs[0] = mkv(1, 32'h0, 0, 0, 2'd0, 1, 0, 0, 2'd0, 4'b0000, 0, '0);
        vecs[1] = mkv(1, 32'h1, 0, 0, 2'd0, 1, 0, 0, 2'd0, 4'b0000, 0, '0);
        vecs[2] = mkv(1, 32'h2, 0, 0, 2'd0, 1, 0, 0, 2'd0, 4'b0000, 0, '0);
        vecs[3] = mkv(1, 32'h3, 0, 1, 2'd3, 1, 0, 1, 2'd3, 4'b0000, 0, '0);
        vecs[4] = mkv(1, 32'h4, 0, 0, 2'd0, 1, 0, 0, 2'd0, 4'b0000, 0, '0);
        vecs[5] = mkv(1, 32'h5, 0, 0, 2'd0, 1, 0, 0, 2'd0, 4'b0000, 0, '0);
        vecs[6] = mkv(1, 32'h6, 0, 0, 2'd0, 1, 0, 0, 2'd0, 4'b0000, 0, '0);
        vecs[7] = mkv(1, 32'h7, 0, 0, 2'd0, 1, 0, 0, 2'd0, 4'b0000, 0, '0);
        vecs[8] = mkv(0, 32'h0, 0, 0, 2'd0, 0, 1, 0, 2'd0, 4'b0000, 1,
                      256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);
        vecs[9] = mkv(0, 32'h0, 0, 0, 2'd0, 1, 0, 0, 2'd0, 4'b0001, 1, '0);

        bus.s_valid = 1'b1; bus.s_data = '0; bus.s_last = 1'b0;
        bus.rd_req = 1'b1; bus.rd_bank = 2'd2;
        bus.rel_valid = 1'b0; bus.rel_bank = 2'd0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        chk("por s_ready",   256'(bus.s_ready),   256'(0));
        chk("por mem_wr",    256'(bus.mem_wr),    256'(0));
        chk("por mem_rd",    256'(bus.mem_rd),    256'(0));
        chk("por bank_full", 256'(bus.bank_full), 256'(0));
        chk("por mem_data",  bus.mem_data,        256'(0));
        @(posedge clock);
        #1;
        bus.s_valid = 1'b0; bus.rd_req = 1'b0; bus.rd_bank = 2'd0;
        reset_n = 1'b1;

        // Full line 0..7 into bank 0.
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].rq, vecs[i].rb, 1'b0, 2'd0);
            chk($sformatf("vec%0d ctl{rdy,wr,rd,bank,full}", i),
                256'({bus.s_ready, bus.mem_wr, bus.mem_rd, bus.mem_bank, bus.bank_full}),
                256'({vecs[i].e_rdy, vecs[i].e_wr, vecs[i].e_rd, vecs[i].e_bank, vecs[i].e_full}));
            if (vecs[i].chk_data) chk($sformatf("vec%0d mem_data", i), bus.mem_data, vecs[i].e_data);
        end

        // All four banks full, then release bank 0 to resume.
        send_line(32'h20, 8, 2'd1);
        send_line(32'h30, 8, 2'd2);
        send_line(32'h40, 8, 2'd3);
        idle();
        chk("full bank_full", 256'(bus.bank_full), 256'(4'b1111));
        chk("full s_ready",   256'(bus.s_ready),   256'(0));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h50, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
            chk($sformatf("stall%0d s_ready", i), 256'(bus.s_ready), 256'(0));
            chk($sformatf("stall%0d mem_wr", i),  256'(bus.mem_wr),  256'(0));
        end
        step(1'b1, 32'h50, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0);
        chk("rel0 same-cycle s_ready", 256'(bus.s_ready), 256'(0));
        idle();
        chk("rel0 s_ready",   256'(bus.s_ready),   256'(1));
        chk("rel0 bank_full", 256'(bus.bank_full), 256'(4'b1110));
        send_line(32'h50, 8, 2'd0);
        idle();
        chk("refill bank_full", 256'(bus.bank_full), 256'(4'b1111));

        // Read requests defer a pending write.
        step(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2);
        step(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd3);
        idle();
        chk("relx3 bank_full", 256'(bus.bank_full), 256'(4'b0001));
        for (int i = 0; i < 8; i++) step(1'b1, 32'h60 + 32'(i), 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0);
            chk($sformatf("defer%0d {rd,wr,bank,rdy}", i),
                256'({bus.mem_rd, bus.mem_wr, bus.mem_bank, bus.s_ready}), 256'({1'b1, 1'b0, 2'd2, 1'b0}));
            chk($sformatf("defer%0d mem_data", i), bus.mem_data, mk_line(32'h60, 8));
        end
        idle();
        chk("deferred {rd,wr,bank}", 256'({bus.mem_rd, bus.mem_wr, bus.mem_bank}), 256'({1'b0, 1'b1, 2'd1}));
        chk("deferred mem_data", bus.mem_data, mk_line(32'h60, 8));
        idle();
        chk("deferred bank_full", 256'(bus.bank_full), 256'(4'b0011));

        // Short line flushed by s_last, zero-filled above word 2.
        for (int i = 0; i < 3; i++) step(1'b1, 32'hA + 32'(i), (i == 2), 1'b0, 2'd0, 1'b0, 2'd0);
        idle();
        chk("short mem_wr",   256'(bus.mem_wr),   256'(1));
        chk("short mem_bank", 256'(bus.mem_bank), 256'(2));
        chk("short mem_data", bus.mem_data, {160'h0, 32'h0000000C, 32'h0000000B, 32'h0000000A});
        idle();
        chk("short bank_full", 256'(bus.bank_full), 256'(4'b0111));
        send_line(32'hD, 1, 2'd3);
        idle();
        chk("single bank_full", 256'(bus.bank_full), 256'(4'b1111));

        // Reset mid-fill discards the partial line.
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h80 + 32'(i), 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
            chk($sformatf("partial%0d s_ready", i), 256'(bus.s_ready), 256'(1));
        end
        pulse_reset();
        send_line(32'h10, 8, 2'd0);
        idle();
        chk("post-reset bank_full", 256'(bus.bank_full), 256'(4'b0001));

        // Release and set on the same edge.
        send_line(32'h71, 1, 2'd1);
        send_line(32'h72, 1, 2'd2);
        send_line(32'h73, 1, 2'd3);
        step(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd3);
        step(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0);
        idle();
        chk("rel013 bank_full", 256'(bus.bank_full), 256'(4'b0100));
        send_line(32'h74, 1, 2'd0);
        step(1'b1, 32'h75, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        chk("pre-sim bank_full", 256'(bus.bank_full), 256'(4'b0101));
        step(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2);
        chk("sim {wr,bank}", 256'({bus.mem_wr, bus.mem_bank}), 256'({1'b1, 2'd1}));
        idle();
        chk("sim bank_full", 256'(bus.bank_full), 256'(4'b0011));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
